// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data memory responder.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 64;
  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DEPTH_LOG2 = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port and one registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  rzero,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // rzero forces a zero result for loads that must not see the array
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rzero ? '0 : mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data memory with power-on clear sequencer; optional range checker
// compiled in with `define DMEM_RANGE_CHK_EN (adds the range_err port).
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_enable,
  input  logic                  store_enable,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_dataIn,
  output logic [DATA_WIDTH-1:0] dmem_dataOut,
  output logic                  init_busy
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic                  range_err
`endif
);

`ifdef DMEM_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  dmem_state_e           state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_busy_q, init_busy_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_hi_nz;
  logic                  oor;
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  re;
  logic                  rzero;

  assign idx        = dmem_address[DEPTH_LOG2-1:0];
  assign addr_hi_nz = (dmem_address >> DEPTH_LOG2) != '0;
  // Without the checker oor is constant 0, so high address bits simply alias
  assign oor        = RANGE_CHK && addr_hi_nz;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we        = 1'b0;
    waddr     = idx;
    wdata     = dmem_dataIn;
    re        = 1'b0;
    rzero     = 1'b0;
    case (state_q)
      CLEAR: begin
        we        = 1'b1;
        waddr     = clr_cnt_q;
        wdata     = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        re        = mem_enable && !store_enable;
        rzero     = 1'b1;
        if (&clr_cnt_q) begin
          state_d = READY;
        end
      end
      default: begin
        if (mem_enable) begin
          if (store_enable) begin
            we = !oor;
          end else begin
            re    = 1'b1;
            rzero = oor;
          end
        end
      end
    endcase
    init_busy_d = (state_d == CLEAR);
  end

`ifdef DMEM_RANGE_CHK_EN
  logic range_err_q, range_err_d;
  assign range_err_d = range_err_q || (state_q == READY && mem_enable && oor);
  assign range_err   = range_err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
`ifdef DMEM_RANGE_CHK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
`ifdef DMEM_RANGE_CHK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  assign init_busy = init_busy_q;

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .rst_n(rst),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .rzero(rzero),
    .raddr(idx),
    .rdata(dmem_dataOut)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder against a word-level memory model.
module tb_data_memory_responder;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DL    = 8;
  localparam int WORDS = 256;
`ifdef DMEM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          busy;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_enable = 1'b0;
  logic          store_enable = 1'b0;
  logic [AW-1:0] dmem_address = '0;
  logic [DW-1:0] dmem_dataIn = '0;
  logic [DW-1:0] dmem_dataOut;
  logic          init_busy;
`ifdef DMEM_RANGE_CHK_EN
  logic          range_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mref [WORDS];
  int            clear_left;
  logic [DW-1:0] out_m;
  logic          err_m;
  exp_t          q[$];

  data_memory_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_enable  (mem_enable),
    .store_enable(store_enable),
    .dmem_address(dmem_address),
    .dmem_dataIn (dmem_dataIn),
    .dmem_dataOut(dmem_dataOut),
    .init_busy   (init_busy)
`ifdef DMEM_RANGE_CHK_EN
    ,
    .range_err   (range_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory is all-zero once a reset has been followed by a complete clear
  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) mref[i] = '0;
    clear_left = WORDS;
    out_m      = '0;
    err_m      = 1'b0;
  endtask

  task automatic step(input bit en, input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   bad;
    mem_enable   = en;
    store_enable = st;
    dmem_address = a;
    dmem_dataIn  = d;
    @(posedge clk);
    if (clear_left > 0) begin
      if (en && !st) out_m = '0;
      clear_left--;
    end else if (en) begin
      bad = CHK && (a >= WORDS);
      if (bad) err_m = 1'b1;
      if (st) begin
        if (!bad) mref[a % WORDS] = d;
      end else begin
        out_m = bad ? '0 : mref[a % WORDS];
      end
    end
    e.d    = out_m;
    e.busy = (clear_left > 0);
    e.err  = err_m;
    q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst        = 1'b0;
    mem_enable = 1'b0;
    #2;
    chk("rst_dout", dmem_dataOut, '0);
    chk("rst_busy", {63'd0, init_busy}, 64'd1);
`ifdef DMEM_RANGE_CHK_EN
    chk("rst_err", {63'd0, range_err}, 64'd0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic clear_phase(input bit inject);
    int edges = 0;
    while (init_busy === 1'b1 && edges < 300) begin
      if (inject && edges == 10) step(1'b1, 1'b1, 32'd300, 64'hFF);
      else step(1'($urandom % 2), 1'($urandom % 2), $urandom_range(0, 511), {$urandom, $urandom});
      edges++;
    end
    chk("clear_cycles", 64'(edges), 64'd256);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dout", dmem_dataOut, e.d);
      chk("busy", {63'd0, init_busy}, {63'd0, e.busy});
`ifdef DMEM_RANGE_CHK_EN
      chk("range_err", {63'd0, range_err}, {63'd0, e.err});
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    clear_phase(1'b1);

    step(1'b1, 1'b0, 32'h2A, '0);
    step(1'b1, 1'b0, 32'd300 % WORDS, '0);
    step(1'b1, 1'b1, 32'd5, 64'hDEADBEEF_01234567);
    step(1'b1, 1'b0, 32'd5, '0);
    repeat (3) step(1'b0, 1'b0, $urandom, {$urandom, $urandom});
    step(1'b1, 1'b1, 32'd6, 64'h1111_2222_3333_4444);
    step(1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 32'd6, '0);
    step(1'b1, 1'b1, 32'h105, 64'hAAAA_5555_AAAA_5555);
    step(1'b1, 1'b0, 32'd5, '0);
    step(1'b1, 1'b0, 32'h105, '0);

    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] a;
      a = ($urandom % 8 == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom % 2), a, {$urandom, $urandom});
    end

    do_reset();
    repeat (100) step(1'b0, 1'b0, '0, '0);
    do_reset();
    clear_phase(1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'($urandom % 4 == 0), AW'($urandom_range(0, 300)), {$urandom, $urandom});
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
